div_sign_ctrl: RTL and testbench
================================

// Module: div_sign_ctrl
// PURPOSE
//  Request front-end and result back-end for the unsigned iterative divider (vld/a/b -> ack/quo/rem).
//  Accepts signed or unsigned DIV/REM ops on a valid/ready port and converts operands to magnitudes.
//  Issues the magnitudes to the divider, then restores signs on quo/rem and returns one tagged result.
//  Divide-by-zero and signed overflow are resolved locally; the divider is never started for them.
// PARAMETERS
//  XLEN     32   operand/result width
//  TAG_W    4    width of the request tag carried to the result
//  TMO_CYC  64   max cycles in WAIT for div_ack before the watchdog fires (must be > divider latency)
// PORTS
//  clk      in   1       system clock
//  rst_n    in   1       system reset: one clock; reset is synchronous and active-high
//  in_vld   in   1       request valid
//  in_rdy   out  1       request ready; high only in IDLE
//  in_op    in   2       00 DIV (signed), 01 DIVU, 10 REM (signed), 11 REMU
//  in_a     in   XLEN    dividend
//  in_b     in   XLEN    divisor
//  in_tag   in   TAG_W   request tag
//  div_vld  out  1       one-cycle start pulse to divider
//  div_a    out  XLEN    |dividend|, held stable from ISSUE through WAIT
//  div_b    out  XLEN    |divisor|, held stable from ISSUE through WAIT
//  div_ack  in   1       divider done pulse; div_quo/div_rem valid in that cycle
//  div_quo  in   XLEN    unsigned quotient
//  div_rem  in   XLEN    unsigned remainder
//  out_vld  out  1       result valid; held until out_rdy
//  out_rdy  in   1       result ready
//  out_res  out  XLEN    quotient (DIV/DIVU) or remainder (REM/REMU)
//  out_tag  out  TAG_W   tag of the request
//  out_dz   out  1       divisor was zero
//  out_ovf  out  1       signed overflow (DIV/REM, a = -2^(XLEN-1), b = -1)
//  out_err  out  1       watchdog timeout
// BEHAVIOUR
//  Reset:
//   - state = IDLE; in_rdy = 1; all other outputs = 0.
//   - Watchdog counter cleared.
//   - Reset in any state abandons the op with no result.
//  FSM: IDLE -> ISSUE -> WAIT -> OUT -> IDLE. Fast path IDLE -> OUT.
//  IDLE:
//   - On in_vld & in_rdy (cycle N), register op/a/b/tag, the sign flags, and the magnitudes
//     (|-2^(XLEN-1)| = 2^(XLEN-1), fits unsigned).
//   - If b == 0 or signed overflow, go to OUT: out_vld = 1 at N+1, div_vld never asserted.
//   - Otherwise go to ISSUE.
//  ISSUE: div_vld = 1 for exactly this cycle (N+1); go to WAIT; watchdog counter cleared.
//  WAIT:
//   - Counter increments each cycle.
//   - On div_ack (cycle M), register the sign-fixed result and go to OUT; out_vld = 1 at M+1.
//     Quotient sign = sa^sb, remainder sign = sa (signed ops only); the result truncates toward zero.
//   - If the counter reaches TMO_CYC without div_ack, go to OUT with out_err = 1, out_res = 0.
//  OUT: outputs held stable while out_vld & !out_rdy; on out_rdy go to IDLE (in_rdy = 1 the next cycle).
//  div_ack outside WAIT (late ack after timeout or reset) is ignored.
//  Fixed results:
//   - b = 0: DIV/DIVU -> all ones; REM/REMU -> a; out_dz = 1.
//   - Overflow: DIV -> -2^(XLEN-1); REM -> 0; out_ovf = 1.
//  Only one op in flight; no new request is accepted until the result handshake completes.
// TESTING
//  - DIVU 10/7, tag 3 -> div_vld pulse, div_a = 10, div_b = 7; out_res = 1, out_tag = 3, flags 0.
//  - DIV -100/7 -> div_a = 100; out_res = -14 (0xFFFFFFF2). REM -7/2 -> out_res = -1. REM 7/-2 -> 1.
//  - DIVU 100/0 -> out_vld at N+1, out_res = 0xFFFFFFFF, out_dz = 1, div_vld never high.
//    REMU 100/0 -> out_res = 100.
//  - DIV 0x80000000/0xFFFFFFFF -> out_res = 0x80000000, out_ovf = 1, no div_vld.
//    REM on the same operands -> 0.
//  - DIVU 100/100 with out_rdy low 5 cycles -> out_vld/out_res = 1 held, in_rdy = 0 throughout.
//    Next request accepted only after release.
//  - div_ack tied low -> out_err = 1 after TMO_CYC cycles. rst_n asserted in WAIT -> IDLE, no out_vld,
//    a later div_ack is ignored.

Source files
------------

// File: rtl/div_sign_ctrl.sv
// Signed/unsigned DIV/REM front-end and back-end around an unsigned iterative divider.
// Handles divide-by-zero and signed overflow locally and guards the divider with a watchdog.
module div_sign_ctrl #(
   parameter int unsigned XLEN    = 32,
   parameter int unsigned TAG_W   = 4,
   parameter int unsigned TMO_CYC = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_vld,
   output logic             in_rdy,
   input  logic [1:0]       in_op,
   input  logic [XLEN-1:0]  in_a,
   input  logic [XLEN-1:0]  in_b,
   input  logic [TAG_W-1:0] in_tag,
   output logic             div_vld,
   output logic [XLEN-1:0]  div_a,
   output logic [XLEN-1:0]  div_b,
   input  logic             div_ack,
   input  logic [XLEN-1:0]  div_quo,
   input  logic [XLEN-1:0]  div_rem,
   output logic             out_vld,
   input  logic             out_rdy,
   output logic [XLEN-1:0]  out_res,
   output logic [TAG_W-1:0] out_tag,
   output logic             out_dz,
   output logic             out_ovf,
   output logic             out_err
);

   localparam int unsigned CntW = $clog2(TMO_CYC + 1);
   localparam logic [XLEN-1:0] Zero   = '0;
   localparam logic [XLEN-1:0] IntMin = {1'b1, {(XLEN-1){1'b0}}};
   localparam logic [CntW-1:0] CntLast = CntW'(TMO_CYC - 1);

   typedef enum logic [1:0] {StIdle, StIssue, StWait, StOut} state_e;

   state_e            state_q;
   logic [CntW-1:0]   cnt_q;
   logic [TAG_W-1:0]  tag_q;
   logic              is_rem_q;
   logic              sa_q;
   logic              sb_q;

   // Request decode
   logic              in_signed;
   logic              in_sa;
   logic              in_sb;
   logic [XLEN-1:0]   in_mag_a;
   logic [XLEN-1:0]   in_mag_b;
   logic              in_dz;
   logic              in_ovf;
   logic [XLEN-1:0]   in_fixed_res;

   always_comb begin
      in_signed = ~in_op[0];
      in_sa     = in_signed & in_a[XLEN-1];
      in_sb     = in_signed & in_b[XLEN-1];
      // Negating -2^(XLEN-1) wraps to itself, which is the correct unsigned magnitude.
      in_mag_a  = in_sa ? (Zero - in_a) : in_a;
      in_mag_b  = in_sb ? (Zero - in_b) : in_b;
      in_dz     = (in_b == Zero);
      in_ovf    = in_signed & (in_a == IntMin) & (in_b == '1);
      if (in_op[1]) begin
         in_fixed_res = in_dz ? in_a : Zero;
      end else begin
         in_fixed_res = in_dz ? '1 : IntMin;
      end
   end

   // Sign restore: quotient takes sa^sb, remainder takes the dividend sign.
   logic [XLEN-1:0] quo_fix;
   logic [XLEN-1:0] rem_fix;
   logic [XLEN-1:0] ack_res;

   always_comb begin
      quo_fix = (sa_q ^ sb_q) ? (Zero - div_quo) : div_quo;
      rem_fix = sa_q ? (Zero - div_rem) : div_rem;
      ack_res = is_rem_q ? rem_fix : quo_fix;
   end

   always_ff @(posedge clk) begin
      if (rst_n) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         tag_q    <= '0;
         is_rem_q <= 1'b0;
         sa_q     <= 1'b0;
         sb_q     <= 1'b0;
         in_rdy   <= 1'b1;
         div_vld  <= 1'b0;
         div_a    <= '0;
         div_b    <= '0;
         out_vld  <= 1'b0;
         out_res  <= '0;
         out_tag  <= '0;
         out_dz   <= 1'b0;
         out_ovf  <= 1'b0;
         out_err  <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (in_vld && in_rdy) begin
                  in_rdy   <= 1'b0;
                  tag_q    <= in_tag;
                  is_rem_q <= in_op[1];
                  sa_q     <= in_sa;
                  sb_q     <= in_sb;
                  div_a    <= in_mag_a;
                  div_b    <= in_mag_b;
                  if (in_dz || in_ovf) begin
                     out_vld <= 1'b1;
                     out_res <= in_fixed_res;
                     out_tag <= in_tag;
                     out_dz  <= in_dz;
                     out_ovf <= in_ovf;
                     out_err <= 1'b0;
                     state_q <= StOut;
                  end else begin
                     div_vld <= 1'b1;
                     state_q <= StIssue;
                  end
               end
            end
            StIssue: begin
               div_vld <= 1'b0;
               cnt_q   <= '0;
               state_q <= StWait;
            end
            StWait: begin
               if (div_ack) begin
                  out_vld <= 1'b1;
                  out_res <= ack_res;
                  out_tag <= tag_q;
                  out_dz  <= 1'b0;
                  out_ovf <= 1'b0;
                  out_err <= 1'b0;
                  state_q <= StOut;
               end else if (cnt_q == CntLast) begin
                  out_vld <= 1'b1;
                  out_res <= '0;
                  out_tag <= tag_q;
                  out_dz  <= 1'b0;
                  out_ovf <= 1'b0;
                  out_err <= 1'b1;
                  state_q <= StOut;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            StOut: begin
               if (out_rdy) begin
                  out_vld <= 1'b0;
                  in_rdy  <= 1'b1;
                  state_q <= StIdle;
               end
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_div_sign_ctrl.sv
// Scoreboard bench for div_sign_ctrl: directed ops, stub divider, result and issue monitors.
module tb_div_sign_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        in_vld = 1'b0;
   logic        in_rdy;
   logic [1:0]  in_op = '0;
   logic [31:0] in_a = '0;
   logic [31:0] in_b = '0;
   logic [3:0]  in_tag = '0;
   logic        div_vld;
   logic [31:0] div_a;
   logic [31:0] div_b;
   logic        div_ack;
   logic [31:0] div_quo;
   logic [31:0] div_rem;
   logic        out_vld;
   logic        out_rdy = 1'b1;
   logic [31:0] out_res;
   logic [3:0]  out_tag;
   logic        out_dz;
   logic        out_ovf;
   logic        out_err;

   logic        ack_model = 1'b0;
   logic        ack_manual = 1'b0;
   logic [31:0] mod_quo = '0;
   logic [31:0] mod_rem = '0;
   logic        resp_en = 1'b1;

   assign div_ack = ack_model | ack_manual;
   assign div_quo = ack_manual ? 32'h1234_5678 : mod_quo;
   assign div_rem = ack_manual ? 32'h0000_0003 : mod_rem;

   always #5 clk = ~clk;

   div_sign_ctrl #(.XLEN(32), .TAG_W(4), .TMO_CYC(64)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .in_vld  (in_vld),
      .in_rdy  (in_rdy),
      .in_op   (in_op),
      .in_a    (in_a),
      .in_b    (in_b),
      .in_tag  (in_tag),
      .div_vld (div_vld),
      .div_a   (div_a),
      .div_b   (div_b),
      .div_ack (div_ack),
      .div_quo (div_quo),
      .div_rem (div_rem),
      .out_vld (out_vld),
      .out_rdy (out_rdy),
      .out_res (out_res),
      .out_tag (out_tag),
      .out_dz  (out_dz),
      .out_ovf (out_ovf),
      .out_err (out_err)
   );

   typedef struct {
      logic [31:0] res;
      logic [3:0]  tag;
      logic        dz;
      logic        ovf;
      logic        err;
   } exp_t;

   exp_t        sb_q[$];
   logic [63:0] div_q[$];
   int          n_cmp = 0;
   int          n_bad = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", name, got, want);
      end
   endtask

   task automatic expect_res(input logic [31:0] res, input logic [3:0] tag,
                             input logic dz, input logic ovf, input logic err);
      exp_t e;
      e.res = res; e.tag = tag; e.dz = dz; e.ovf = ovf; e.err = err;
      sb_q.push_back(e);
   endtask

   task automatic expect_div(input logic [31:0] a, input logic [31:0] b);
      div_q.push_back({a, b});
   endtask

   task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] tag, input logic fast);
      int t = 0;
      @(negedge clk);
      while (!in_rdy && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (!in_rdy) begin
         chk("in_rdy_timeout", {31'd0, in_rdy}, 32'd1);
         return;
      end
      in_vld = 1'b1; in_op = op; in_a = a; in_b = b; in_tag = tag;
      @(negedge clk);
      in_vld = 1'b0;
      if (fast) begin
         chk("fast_out_vld", {31'd0, out_vld}, 32'd1);
         chk("fast_no_div_vld", {31'd0, div_vld}, 32'd0);
      end
   endtask

   task automatic drain(input int budget);
      int t = 0;
      while ((sb_q.size() != 0 || !in_rdy) && t < budget) begin
         @(negedge clk);
         t++;
      end
      chk("drain_pending", sb_q.size(), 32'd0);
   endtask

   // Stub divider: answers a few cycles after each start pulse.
   initial begin
      logic [31:0] ra, rb;
      forever begin
         @(negedge clk);
         if (div_vld && resp_en) begin
            ra = div_a;
            rb = div_b;
            repeat (3) @(negedge clk);
            mod_quo   = (rb == 0) ? 32'hFFFF_FFFF : ra / rb;
            mod_rem   = (rb == 0) ? ra : ra % rb;
            ack_model = 1'b1;
            @(negedge clk);
            ack_model = 1'b0;
         end
      end
   end

   // Monitors: result handshakes and divider start pulses.
   initial begin
      exp_t        e;
      logic [63:0] d;
      forever begin
         @(negedge clk);
         if (out_vld && out_rdy) begin
            n_cmp++;
            if (sb_q.size() == 0) begin
               n_bad++;
               $display("FAIL unexpected_result: got res=%h tag=%h, none expected", out_res, out_tag);
            end else begin
               e = sb_q.pop_front();
               if (out_res !== e.res || out_tag !== e.tag || out_dz !== e.dz ||
                   out_ovf !== e.ovf || out_err !== e.err) begin
                  n_bad++;
                  $display("FAIL result: got res=%h tag=%h dz=%b ovf=%b err=%b want res=%h tag=%h dz=%b ovf=%b err=%b",
                           out_res, out_tag, out_dz, out_ovf, out_err,
                           e.res, e.tag, e.dz, e.ovf, e.err);
               end
            end
         end
         if (div_vld) begin
            n_cmp++;
            if (div_q.size() == 0) begin
               n_bad++;
               $display("FAIL unexpected_div_vld: got a=%h b=%h, none expected", div_a, div_b);
            end else begin
               d = div_q.pop_front();
               if (div_a !== d[63:32] || div_b !== d[31:0]) begin
                  n_bad++;
                  $display("FAIL div_issue: got a=%h b=%h want a=%h b=%h",
                           div_a, div_b, d[63:32], d[31:0]);
               end
            end
         end
      end
   end

   initial begin
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk("rst_in_rdy", {31'd0, in_rdy}, 32'd1);
      chk("rst_out_vld", {31'd0, out_vld}, 32'd0);
      chk("rst_div_vld", {31'd0, div_vld}, 32'd0);
      chk("rst_out_res", out_res, 32'd0);
      chk("rst_out_err", {31'd0, out_err}, 32'd0);

      // Divider path, sign handling
      expect_div(32'd10, 32'd7);   expect_res(32'd1, 4'd3, 1'b0, 1'b0, 1'b0);
      send(2'b01, 32'd10, 32'd7, 4'd3, 1'b0);
      expect_div(32'd100, 32'd7);  expect_res(32'hFFFF_FFF2, 4'd4, 1'b0, 1'b0, 1'b0);
      send(2'b00, 32'hFFFF_FF9C, 32'd7, 4'd4, 1'b0);
      expect_div(32'd7, 32'd2);    expect_res(32'hFFFF_FFFF, 4'd5, 1'b0, 1'b0, 1'b0);
      send(2'b10, 32'hFFFF_FFF9, 32'd2, 4'd5, 1'b0);
      expect_div(32'd7, 32'd2);    expect_res(32'd1, 4'd6, 1'b0, 1'b0, 1'b0);
      send(2'b10, 32'd7, 32'hFFFF_FFFE, 4'd6, 1'b0);
      expect_div(32'd7, 32'd2);    expect_res(32'hFFFF_FFFD, 4'd7, 1'b0, 1'b0, 1'b0);
      send(2'b00, 32'd7, 32'hFFFF_FFFE, 4'd7, 1'b0);
      expect_div(32'h8000_0000, 32'd2); expect_res(32'hC000_0000, 4'd8, 1'b0, 1'b0, 1'b0);
      send(2'b00, 32'h8000_0000, 32'd2, 4'd8, 1'b0);
      expect_div(32'h8000_0000, 32'hFFFF_FFFF); expect_res(32'd0, 4'd9, 1'b0, 1'b0, 1'b0);
      send(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 4'd9, 1'b0);
      drain(100);

      // Fast paths: divide-by-zero and signed overflow
      expect_res(32'hFFFF_FFFF, 4'd10, 1'b1, 1'b0, 1'b0);
      send(2'b01, 32'd100, 32'd0, 4'd10, 1'b1);
      expect_res(32'd100, 4'd11, 1'b1, 1'b0, 1'b0);
      send(2'b11, 32'd100, 32'd0, 4'd11, 1'b1);
      expect_res(32'hFFFF_FFFF, 4'd12, 1'b1, 1'b0, 1'b0);
      send(2'b00, 32'd0, 32'd0, 4'd12, 1'b1);
      expect_res(32'h8000_0000, 4'd13, 1'b0, 1'b1, 1'b0);
      send(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 4'd13, 1'b1);
      expect_res(32'd0, 4'd14, 1'b0, 1'b1, 1'b0);
      send(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 4'd14, 1'b1);
      drain(100);

      // Back-pressure: result held while out_rdy is low
      out_rdy = 1'b0;
      expect_div(32'd100, 32'd100); expect_res(32'd1, 4'd15, 1'b0, 1'b0, 1'b0);
      send(2'b01, 32'd100, 32'd100, 4'd15, 1'b0);
      begin
         int t = 0;
         while (!out_vld && t < 50) begin
            @(negedge clk);
            t++;
         end
      end
      for (int i = 0; i < 5; i++) begin
         chk("hold_out_vld", {31'd0, out_vld}, 32'd1);
         chk("hold_out_res", out_res, 32'd1);
         chk("hold_in_rdy", {31'd0, in_rdy}, 32'd0);
         @(negedge clk);
      end
      @(posedge clk);
      #1 out_rdy = 1'b1;
      expect_div(32'd9, 32'd4); expect_res(32'd1, 4'd2, 1'b0, 1'b0, 1'b0);
      send(2'b11, 32'd9, 32'd4, 4'd2, 1'b0);
      drain(100);

      // Watchdog, then a late ack that must be ignored
      resp_en = 1'b0;
      expect_div(32'd5, 32'd1); expect_res(32'd0, 4'd1, 1'b0, 1'b0, 1'b1);
      send(2'b01, 32'd5, 32'd1, 4'd1, 1'b0);
      drain(300);
      ack_manual = 1'b1;
      @(negedge clk);
      ack_manual = 1'b0;
      repeat (3) @(negedge clk);
      chk("late_ack_out_vld", {31'd0, out_vld}, 32'd0);
      chk("late_ack_in_rdy", {31'd0, in_rdy}, 32'd1);

      // Reset while waiting for the divider
      expect_div(32'd50, 32'd3);
      send(2'b01, 32'd50, 32'd3, 4'd0, 1'b0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk("wait_rst_in_rdy", {31'd0, in_rdy}, 32'd1);
      chk("wait_rst_out_vld", {31'd0, out_vld}, 32'd0);
      ack_manual = 1'b1;
      @(negedge clk);
      ack_manual = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("post_rst_ack_out_vld", {31'd0, out_vld}, 32'd0);
      end
      resp_en = 1'b1;

      // Still functional after reset
      expect_div(32'd21, 32'd4); expect_res(32'hFFFF_FFFB, 4'd6, 1'b0, 1'b0, 1'b0);
      send(2'b00, 32'd21, 32'hFFFF_FFFC, 4'd6, 1'b0);
      drain(100);
      chk("div_issue_pending", div_q.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
